// File: rtl/ysyx_23060203_gpr_scoreboard_if.sv
// ysyx_23060203_gpr_scoreboard_if
//   Bundles the IDU issue, WBU commit, operand lookup and status signals of
//   the GPR scoreboard.
//   master : IDU/WBU side (drives issue/commit/lookup, observes status)
//   slave  : scoreboard side
//   Signals:
//     flush                    pipeline flush, discards all pending writes
//     issue_valid, issue_rd    IDU->EXU transfer and its destination GPR
//     issue_ready              scoreboard can accept issue_rd this cycle
//     rs1/rs1_en, rs2/rs2_en   source operand lookup
//     rs1_busy, rs2_busy       source has a pending write
//     raw_stall                enabled source is busy
//     commit_valid, commit_rd  WBU retires a GPR write
//     inflight, idle           total pending writes / none pending
//     err                      sticky commit-underflow flag
interface ysyx_23060203_gpr_scoreboard_if #(
    parameter int TOTAL_W = 3
);
    logic               flush;
    logic               issue_valid;
    logic [4:0]         issue_rd;
    logic               issue_ready;
    logic [4:0]         rs1;
    logic               rs1_en;
    logic [4:0]         rs2;
    logic               rs2_en;
    logic               rs1_busy;
    logic               rs2_busy;
    logic               raw_stall;
    logic               commit_valid;
    logic [4:0]         commit_rd;
    logic [TOTAL_W-1:0] inflight;
    logic               idle;
    logic               err;

    modport master (
        output flush, issue_valid, issue_rd, rs1, rs1_en, rs2, rs2_en,
               commit_valid, commit_rd,
        input  issue_ready, rs1_busy, rs2_busy, raw_stall, inflight, idle, err
    );

    modport slave (
        input  flush, issue_valid, issue_rd, rs1, rs1_en, rs2, rs2_en,
               commit_valid, commit_rd,
        output issue_ready, rs1_busy, rs2_busy, raw_stall, inflight, idle, err
    );
endinterface

// File: rtl/ysyx_23060203_gpr_scoreboard.sv
// ysyx_23060203_gpr_scoreboard
//   Tracks GPR writes in flight between IDU issue and WBU commit. Each of
//   x1..x31 has a saturating-by-throttle pending counter; a global counter
//   tracks the total. Busy/stall outputs come from registered state only.
//   Ports:
//     clock  system clock
//     reset  asynchronous, active-high reset
//     sb     scoreboard interface (slave modport), see the interface file
module ysyx_23060203_gpr_scoreboard #(
    parameter int CNT_W   = 2,
    parameter int TOTAL_W = 3
) (
    input  logic clock,
    input  logic reset,
    ysyx_23060203_gpr_scoreboard_if.slave sb
);

    localparam logic [CNT_W-1:0]   MAX_CNT = '1;
    localparam logic [TOTAL_W-1:0] MAX_TOT = '1;

    // Entry 0 is never written, so it reads as zero and x0 is never busy.
    logic [CNT_W-1:0]   cnt_q [32];
    logic [CNT_W-1:0]   cnt_d [32];
    logic [TOTAL_W-1:0] total_q, total_d;
    logic               err_q, err_d;

    logic iss, cmt, cmt_same, underflow, ready;
    logic cmt_rd_nz, cmt_cnt_nz;

    always_comb begin
        cmt_rd_nz  = (sb.commit_rd != 5'd0);
        cmt_cnt_nz = (cnt_q[sb.commit_rd] != '0);
        cmt        = sb.commit_valid & ~sb.flush & cmt_rd_nz & cmt_cnt_nz;
        underflow  = sb.commit_valid & ~sb.flush & cmt_rd_nz & ~cmt_cnt_nz;
        cmt_same   = cmt & (sb.commit_rd == sb.issue_rd);
        // A same-cycle commit frees the slot the issue needs, so it may
        // proceed even when the counter is at its maximum.
        ready      = (sb.issue_rd == 5'd0) |
                     (((cnt_q[sb.issue_rd] != MAX_CNT) | cmt_same) &
                      ((total_q != MAX_TOT) | cmt));
        iss        = sb.issue_valid & ready & ~sb.flush & (sb.issue_rd != 5'd0);
    end

    always_comb begin
        cnt_d   = cnt_q;
        total_d = total_q;
        err_d   = err_q | underflow;
        if (sb.flush) begin
            for (int unsigned i = 0; i < 32; i++) begin
                cnt_d[i] = '0;
            end
            total_d = '0;
        end else begin
            if (iss) begin
                cnt_d[sb.issue_rd] = cnt_q[sb.issue_rd] + CNT_W'(1);
            end
            // Reads cnt_d so a same-rd issue+commit nets to no change.
            if (cmt) begin
                cnt_d[sb.commit_rd] = cnt_d[sb.commit_rd] - CNT_W'(1);
            end
            total_d = total_q + TOTAL_W'(iss) - TOTAL_W'(cmt);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int unsigned i = 1; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            cnt_q[0] <= '0;
            total_q  <= total_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        sb.issue_ready = ready;
        sb.rs1_busy    = (cnt_q[sb.rs1] != '0);
        sb.rs2_busy    = (cnt_q[sb.rs2] != '0);
        sb.raw_stall   = (sb.rs1_en & sb.rs1_busy) | (sb.rs2_en & sb.rs2_busy);
        sb.inflight    = total_q;
        sb.idle        = (total_q == '0);
        sb.err         = err_q;
    end

endmodule
